// File: rtl/conv_tx_pkg.sv
// rtl/conv_tx_pkg.sv - state encoding and frame constants shared by the conv_frame_tx slice
package conv_tx_pkg;

  localparam int CONV_LANES = 4;
  localparam int CONV_WIDTH = 6;
  localparam int CONV_RES_W = 14;

  // Raw encodings kept as plain constants so legacy code can compare against them directly.
  localparam logic [2:0] ST_IDLE_C    = 3'd0;
  localparam logic [2:0] ST_SEND_W_C  = 3'd1;
  localparam logic [2:0] ST_SEND_I_C  = 3'd2;
  localparam logic [2:0] ST_SETTLE_C  = 3'd3;
  localparam logic [2:0] ST_CAPTURE_C = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_C,
    ST_SEND_W  = ST_SEND_W_C,
    ST_SEND_I  = ST_SEND_I_C,
    ST_SETTLE  = ST_SETTLE_C,
    ST_CAPTURE = ST_CAPTURE_C
  } conv_tx_state_t;

  // True for the phases that put a word on the core's load path.
  function automatic logic is_send_state(input conv_tx_state_t s);
    return (s == ST_SEND_W) || (s == ST_SEND_I);
  endfunction

endpackage

// File: rtl/conv_lane_sel.sv
// rtl/conv_lane_sel.sv - registered LANES:1 word mux picking one lane of the weight or input vector
module conv_lane_sel
  import conv_tx_pkg::*;
#(
  parameter int LANES = CONV_LANES,
  parameter int WIDTH = CONV_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     pick_weights,
  input  logic [$clog2(LANES)-1:0] lane,
  input  logic [LANES*WIDTH-1:0]   weights,
  input  logic [LANES*WIDTH-1:0]   inputs,
  output logic [WIDTH-1:0]         word_q
);

  logic [WIDTH-1:0] word_d;

  // Select the addressed lane; the bus is forced to zero whenever no word is being sent.
  always_comb begin
    word_d = '0;
    if (load) begin
      if (pick_weights) begin
        word_d = weights[lane*WIDTH +: WIDTH];
      end else begin
        word_d = inputs[lane*WIDTH +: WIDTH];
      end
    end
  end

  // Output register so the core sees a clean, glitch-free word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/conv_frame_tx.sv
// rtl/conv_frame_tx.sv - frame serializer for the convolution core; CONV_TX_READBACK_EN adds settle/capture of the result
module conv_frame_tx
  import conv_tx_pkg::*;
#(
  parameter int LANES  = CONV_LANES,
  parameter int WIDTH  = CONV_WIDTH,
  parameter int RES_W  = CONV_RES_W,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  input  logic [LANES*WIDTH-1:0] frame_weights,
  input  logic [LANES*WIDTH-1:0] frame_inputs,
  input  logic                   skip_weights,
  output logic [WIDTH-1:0]       word_out,
  output logic                   word_sel,
  output logic                   word_valid,
  input  logic [RES_W-1:0]       result_in,
  output logic [RES_W-1:0]       result_out,
  output logic                   result_valid,
  output logic                   busy
);

  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  conv_tx_state_t         state_q, state_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic [LANES*WIDTH-1:0] weights_q, weights_d;
  logic [LANES*WIDTH-1:0] inputs_q, inputs_d;
  logic                   word_sel_q, word_sel_d;
  logic                   word_valid_q, word_valid_d;
  logic                   busy_q, busy_d;
  logic                   frame_ready_q, frame_ready_d;

`ifdef CONV_TX_READBACK_EN
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  logic [SW-1:0]    settle_q, settle_d;
  logic [RES_W-1:0] result_out_q, result_out_d;
  logic             result_valid_q, result_valid_d;
`else
  logic unused_result;
  assign unused_result = ^{result_in, SETTLE[0]};
`endif

  // Phase sequencing: accept a frame, walk the lanes of each vector, then optionally wait and capture.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    weights_d = weights_q;
    inputs_d  = inputs_q;
`ifdef CONV_TX_READBACK_EN
    settle_d  = settle_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (frame_valid && frame_ready_q) begin
          weights_d = frame_weights;
          inputs_d  = frame_inputs;
          lane_d    = '0;
          state_d   = skip_weights ? ST_SEND_I : ST_SEND_W;
        end
      end
      ST_SEND_W: begin
        if (lane_q == LAST_LANE) begin
          lane_d  = '0;
          state_d = ST_SEND_I;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      ST_SEND_I: begin
        if (lane_q == LAST_LANE) begin
          lane_d  = '0;
`ifdef CONV_TX_READBACK_EN
          settle_d = '0;
          state_d  = ST_SETTLE;
`else
          state_d  = ST_IDLE;
`endif
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
`ifdef CONV_TX_READBACK_EN
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    word_valid_d  = is_send_state(state_d);
    word_sel_d    = (state_d == ST_SEND_W);
    busy_d        = (state_d != ST_IDLE);
    frame_ready_d = (state_d == ST_IDLE);
`ifdef CONV_TX_READBACK_EN
    result_valid_d = (state_d == ST_CAPTURE);
    result_out_d   = result_valid_d ? result_in : result_out_q;
`endif
  end

  // Control and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lane_q        <= '0;
      weights_q     <= '0;
      inputs_q      <= '0;
      word_sel_q    <= 1'b0;
      word_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      weights_q     <= weights_d;
      inputs_q      <= inputs_d;
      word_sel_q    <= word_sel_d;
      word_valid_q  <= word_valid_d;
      busy_q        <= busy_d;
      frame_ready_q <= frame_ready_d;
    end
  end

`ifdef CONV_TX_READBACK_EN
  // Settle timer and captured result; result_out holds until the next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_q       <= '0;
      result_out_q   <= '0;
      result_valid_q <= 1'b0;
    end else begin
      settle_q       <= settle_d;
      result_out_q   <= result_out_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result_out   = result_out_q;
  assign result_valid = result_valid_q;
`else
  assign result_out   = '0;
  assign result_valid = 1'b0;
`endif

  // Lane mux fed with next-cycle values so the word appears with its valid/sel flags.
  conv_lane_sel #(
    .LANES(LANES),
    .WIDTH(WIDTH)
  ) u_lane_sel (
    .clk         (clk),
    .rst         (rst),
    .load        (word_valid_d),
    .pick_weights(word_sel_d),
    .lane        (lane_d),
    .weights     (weights_d),
    .inputs      (inputs_d),
    .word_q      (word_out)
  );

  assign word_sel    = word_sel_q;
  assign word_valid  = word_valid_q;
  assign busy        = busy_q;
  assign frame_ready = frame_ready_q;

endmodule

// File: tb/tb_conv_frame_tx.sv
// tb/tb_conv_frame_tx.sv - self-checking bench for conv_frame_tx, follows CONV_TX_READBACK_EN
module tb_conv_frame_tx;

  localparam int LANES  = 4;
  localparam int WIDTH  = 6;
  localparam int RES_W  = 14;
  localparam int SETTLE = 2;
  localparam int VW     = LANES * WIDTH;
`ifdef CONV_TX_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             frame_valid = 1'b0;
  logic             frame_ready;
  logic [VW-1:0]    frame_weights = '0;
  logic [VW-1:0]    frame_inputs = '0;
  logic             skip_weights = 1'b0;
  logic [WIDTH-1:0] word_out;
  logic             word_sel;
  logic             word_valid;
  logic [RES_W-1:0] result_in = '0;
  logic [RES_W-1:0] result_out;
  logic             result_valid;
  logic             busy;

  always #5 clk = ~clk;

  conv_frame_tx #(
    .LANES(LANES), .WIDTH(WIDTH), .RES_W(RES_W), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_weights(frame_weights), .frame_inputs(frame_inputs), .skip_weights(skip_weights),
    .word_out(word_out), .word_sel(word_sel), .word_valid(word_valid),
    .result_in(result_in), .result_out(result_out), .result_valid(result_valid), .busy(busy)
  );

  // Reference model: one expected slot per future cycle of an accepted frame.
  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic             sel;
    logic             valid;
    logic             cap;
  } slot_t;

  slot_t pend[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit armed = 1'b0;
  bit rst_prev = 1'b1;
  logic [RES_W-1:0] res_hold = '0;
  logic [RES_W-1:0] res_prev_in = '0;

  int   obs_cycle;
  bit   obs_valid, obs_sel, obs_rv, obs_ready, obs_busy, obs_acc;
  logic [WIDTH-1:0] obs_word;
  logic [RES_W-1:0] obs_rout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic push_frame(input logic [VW-1:0] w, input logic [VW-1:0] x, input bit sk);
    slot_t s;
    if (!sk) begin
      for (int k = 0; k < LANES; k++) begin
        s = '0; s.word = w[k*WIDTH +: WIDTH]; s.sel = 1'b1; s.valid = 1'b1;
        pend.push_back(s);
      end
    end
    for (int k = 0; k < LANES; k++) begin
      s = '0; s.word = x[k*WIDTH +: WIDTH]; s.valid = 1'b1;
      pend.push_back(s);
    end
    if (READBACK) begin
      for (int k = 0; k < SETTLE; k++) begin
        s = '0;
        pend.push_back(s);
      end
      s = '0; s.cap = 1'b1;
      pend.push_back(s);
    end
  endtask

  // One cycle: check outputs against the model, then drive inputs for the coming edge.
  task automatic step(input bit r, input bit fv, input logic [VW-1:0] w, input logic [VW-1:0] x,
                      input bit sk, input logic [RES_W-1:0] res);
    slot_t e;
    bit    have;
    bit    exp_ready;
    @(negedge clk);
    have = (pend.size() != 0);
    e = '0;
    if (have) e = pend.pop_front();
    exp_ready = !have && !rst_prev;
    if (e.cap) res_hold = res_prev_in;
    obs_cycle = cyc;
    obs_valid = word_valid; obs_sel = word_sel; obs_rv = result_valid;
    obs_ready = frame_ready; obs_busy = busy; obs_word = word_out; obs_rout = result_out;
    if (armed) begin
      check("word_valid", 32'(word_valid), 32'(e.valid));
      check("word_sel", 32'(word_sel), 32'(e.sel));
      check("word_out", 32'(word_out), 32'(e.word));
      check("busy", 32'(busy), 32'(have));
      check("frame_ready", 32'(frame_ready), 32'(exp_ready));
      check("result_valid", 32'(result_valid), 32'(e.cap));
      check("result_out", 32'(result_out), 32'(res_hold));
    end
    obs_acc = fv && !r && (frame_ready === 1'b1);
    rst = r; frame_valid = fv; frame_weights = w; frame_inputs = x;
    skip_weights = sk; result_in = res;
    res_prev_in = res;
    if (r) begin
      pend.delete();
      res_hold = '0;
    end else if (fv && exp_ready) begin
      push_frame(w, x, sk);
    end
    rst_prev = r;
    cyc++;
  endtask

  typedef struct {
    logic [VW-1:0]    w;
    logic [VW-1:0]    x;
    bit               sk;
    logic [RES_W-1:0] res;
    int               n_w;
    int               n_i;
    int               first_word;
    int               first_sel;
    int               rv_at;
    int               ready_at;
    int               rout;
  } vec_t;

  vec_t vecs[3];

  localparam logic [VW-1:0] NINES = {4{6'd9}};

  // Drive one frame, then measure what the DUT emits relative to the accept edge.
  task automatic run_vec(input vec_t v, input int idx);
    int acc, nw, ni, rv_at, ready_at, guard, fw, fs;
    bit got_first;
    acc = -1; guard = 0;
    while (acc < 0 && guard < 20) begin
      step(1'b0, 1'b1, v.w, v.x, v.sk, v.res);
      if (obs_acc) acc = obs_cycle;
      guard++;
    end
    check($sformatf("vec%0d.accepted", idx), 32'(acc >= 0), 32'd1);
    nw = 0; ni = 0; rv_at = -1; ready_at = -1; guard = 0; got_first = 1'b0; fw = -1; fs = -1;
    while (ready_at < 0 && guard < 40) begin
      step(1'b0, 1'b0, NINES, NINES, 1'b0, v.res);
      if (obs_valid) begin
        if (!got_first) begin fw = int'(obs_word); fs = int'(obs_sel); got_first = 1'b1; end
        if (obs_sel) nw++; else ni++;
      end
      if (obs_rv) rv_at = obs_cycle - acc;
      if (obs_ready) ready_at = obs_cycle - acc;
      guard++;
    end
    check($sformatf("vec%0d.weight_words", idx), 32'(nw), 32'(v.n_w));
    check($sformatf("vec%0d.input_words", idx), 32'(ni), 32'(v.n_i));
    check($sformatf("vec%0d.first_word", idx), 32'(fw), 32'(v.first_word));
    check($sformatf("vec%0d.first_sel", idx), 32'(fs), 32'(v.first_sel));
    check($sformatf("vec%0d.result_valid_cycle", idx), 32'(rv_at), 32'(v.rv_at));
    check($sformatf("vec%0d.frame_ready_cycle", idx), 32'(ready_at), 32'(v.ready_at));
    check($sformatf("vec%0d.result_out", idx), 32'(obs_rout), 32'(v.rout));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] w0, x0, rw, rx;
    logic [RES_W-1:0] rr;
    int accs[$];
    int acc, guard, bad, rv_cnt;

    w0 = {6'd4, 6'd3, 6'd2, 6'd1};
    x0 = {6'd8, 6'd7, 6'd6, 6'd5};
    vecs[0] = '{w: w0, x: x0, sk: 1'b0, res: 14'd70, n_w: 4, n_i: 4, first_word: 1, first_sel: 1,
                rv_at: READBACK ? 11 : -1, ready_at: READBACK ? 12 : 9, rout: READBACK ? 70 : 0};
    vecs[1] = '{w: {6'd33, 6'd22, 6'd11, 6'd44}, x: {4{6'd63}}, sk: 1'b1, res: 14'd15876,
                n_w: 0, n_i: 4, first_word: 63, first_sel: 0,
                rv_at: READBACK ? 7 : -1, ready_at: READBACK ? 8 : 5, rout: READBACK ? 15876 : 0};
    vecs[2] = '{w: {6'd0, 6'd63, 6'd0, 6'd63}, x: {6'd63, 6'd0, 6'd63, 6'd0}, sk: 1'b0,
                res: 14'h3FFF, n_w: 4, n_i: 4, first_word: 63, first_sel: 1,
                rv_at: READBACK ? 11 : -1, ready_at: READBACK ? 12 : 9, rout: READBACK ? 16383 : 0};

    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    armed = 1'b1;
    step(1'b1, 1'b1, w0, x0, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);

    for (int i = 0; i < 3; i++) run_vec(vecs[i], i);

    // frame_valid held across frames: accepts must follow the frame cadence exactly.
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b1, w0, x0, 1'b0, 14'd70);
      if (obs_acc) accs.push_back(obs_cycle);
      if (obs_busy && obs_ready) bad++;
    end
    check("held.ready_while_busy", 32'(bad), 32'd0);
    check("held.two_accepts", 32'(accs.size() >= 2), 32'd1);
    if (accs.size() >= 2) check("held.cadence", 32'(accs[1] - accs[0]), READBACK ? 32'd12 : 32'd9);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 14'd70);

    // Reset on cycle 6 of a frame aborts it without a result.
    acc = -1; guard = 0;
    while (acc < 0 && guard < 20) begin
      step(1'b0, 1'b1, w0, x0, 1'b0, 14'd70);
      if (obs_acc) acc = obs_cycle;
      guard++;
    end
    check("abort.accepted", 32'(acc >= 0), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, NINES, NINES, 1'b0, 14'd70);
    step(1'b1, 1'b0, '0, '0, 1'b0, 14'd70);
    step(1'b0, 1'b0, '0, '0, 1'b0, 14'd70);
    check("abort.word_valid", 32'(obs_valid), 32'd0);
    check("abort.busy", 32'(obs_busy), 32'd0);
    rv_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 14'd70);
      if (obs_rv) rv_cnt++;
    end
    check("abort.no_result_valid", 32'(rv_cnt), 32'd0);
    check("abort.result_out", 32'(obs_rout), 32'd0);

    // Randomised traffic with occasional resets, checked cycle by cycle by the model.
    for (int i = 0; i < 500; i++) begin
      rw = VW'($urandom);
      rx = VW'($urandom);
      rr = RES_W'($urandom);
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) != 0), rw, rx,
           ($urandom_range(0, 3) == 0), rr);
    end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
